cpu4_ctrl_seq: RTL and testbench

Fetch/decode/execute sequencer for the 4-bit TinyTapeout CPU. It owns the PC and the instruction register. It drives the instruction-memory and data-memory request/ack handshakes. It issues the per-instruction strobes to the ALU, accumulator, flag and output datapath, which are built from SG13G2 cells, and it sequences that datapath one instruction at a time.

---
 rtl/cpu4_ctrl_seq.sv | 178 +++++++++++++++++
 tb/tb_cpu4_ctrl_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu4_ctrl_seq.sv
// Fetch/decode/execute sequencer for the 4-bit CPU: owns pc and ir, runs the
// imem/dmem request-ack handshakes and issues one-cycle datapath strobes.
module cpu4_ctrl_seq #(
  parameter int PC_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            step,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [7:0]      imem_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [3:0]      dmem_addr,
  input  logic            dmem_ack,
  input  logic            zero_flag,
  input  logic            carry_flag,
  output logic [3:0]      operand,
  output logic [2:0]      alu_op,
  output logic            alu_src_imm,
  output logic            acc_we,
  output logic            flags_we,
  output logic            out_we,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            fault,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,  OP_XOR, OP_LD,
    OP_ST,  OP_JMP, OP_JZ,  OP_JC,  OP_OUT, OP_INC, OP_NOT, OP_HLT
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_INC, ALU_NOT
  } alu_op_t;

  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

  state_t            st;
  logic [7:0]        ir;
  logic [CNT_W-1:0]  wait_cnt;
  opcode_t           opcode;
  state_t            done_st;
  logic              limit_hit;
  logic              take_jump;
  logic [PC_W-1:0]   jump_target;

  assign opcode      = opcode_t'(ir[7:4]);
  assign done_st     = run ? S_FETCH : S_IDLE;
  // The cycle that would bring the wait count to TIMEOUT; an ack in it still wins.
  assign limit_hit   = (TIMEOUT != 0) && (wait_cnt == CNT_LAST);
  assign jump_target = PC_W'(ir[3:0]);
  assign take_jump   = (opcode == OP_JMP) ||
                       (opcode == OP_JZ && zero_flag) ||
                       (opcode == OP_JC && carry_flag);

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_IDLE;
      pc       <= '0;
      ir       <= '0;
      wait_cnt <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (run || step) begin
            st       <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir <= imem_data;
            pc <= pc + 1'b1;
            st <= S_DECODE;
          end else if (limit_hit) begin
            st <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          wait_cnt <= '0;
          case (opcode)
            OP_LD, OP_ST: st <= S_MEM;
            OP_HLT:       st <= S_HALT;
            default:      st <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          if (take_jump) pc <= jump_target;
          st       <= done_st;
          wait_cnt <= '0;
        end
        S_MEM: begin
          if (dmem_ack) begin
            st       <= done_st;
            wait_cnt <= '0;
          end else if (limit_hit) begin
            st <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_HALT, S_FAULT: st <= st;
        default:         st <= S_IDLE;
      endcase
    end
  end

  assign state     = st;
  assign imem_req  = (st == S_FETCH);
  assign imem_addr = pc;
  assign dmem_req  = (st == S_MEM);
  assign dmem_we   = (st == S_MEM) && (opcode == OP_ST);
  assign dmem_addr = ir[3:0];
  assign operand   = ir[3:0];
  assign halted    = (st == S_HALT);
  assign fault     = (st == S_FAULT);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    alu_op      = ALU_PASS;
    alu_src_imm = 1'b0;
    acc_we      = 1'b0;
    flags_we    = 1'b0;
    out_we      = 1'b0;
    if (st == S_EXEC) begin
      case (opcode)
        OP_LDI: begin
          alu_src_imm = 1'b1;
          acc_we      = 1'b1;
          flags_we    = 1'b1;
        end
        // ADD..XOR opcodes sit exactly one above their ALU encodings.
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
          alu_op      = 3'(ir[7:4] - 4'd1);
          alu_src_imm = 1'b1;
          acc_we      = 1'b1;
          flags_we    = 1'b1;
        end
        OP_INC: begin
          alu_op   = ALU_INC;
          acc_we   = 1'b1;
          flags_we = 1'b1;
        end
        OP_NOT: begin
          alu_op   = ALU_NOT;
          acc_we   = 1'b1;
          flags_we = 1'b1;
        end
        OP_OUT:  out_we = 1'b1;
        default: ;
      endcase
    end else if (st == S_MEM && opcode == OP_LD && dmem_ack) begin
      acc_we   = 1'b1;
      flags_we = 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu4_ctrl_seq.sv
// Self-checking bench for cpu4_ctrl_seq: opcode vector table, hand-written
// handshake/timeout/reset sequences, and random programs against an ISA model.
`timescale 1ns/1ps
module tb_cpu4_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       imem_req, imem_ack;
  logic [3:0] imem_addr;
  logic [7:0] imem_data;
  logic       dmem_req, dmem_we, dmem_ack;
  logic [3:0] dmem_addr;
  logic       zero_flag = 1'b0;
  logic       carry_flag = 1'b0;
  logic [3:0] operand;
  logic [2:0] alu_op;
  logic       alu_src_imm, acc_we, flags_we, out_we;
  logic [3:0] pc;
  logic       halted, fault;
  logic [2:0] state;

  cpu4_ctrl_seq #(.PC_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .operand(operand),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .acc_we(acc_we), .flags_we(flags_we),
    .out_we(out_we), .pc(pc), .halted(halted), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  // Memory responders: ack once a request has waited *_lat cycles.
  logic [7:0]  prog [16];
  int unsigned imem_lat = 0, dmem_lat = 0;
  int unsigned iwait, dwait;
  assign imem_ack  = imem_req && (iwait >= imem_lat);
  assign imem_data = prog[imem_addr];
  assign dmem_ack  = dmem_req && (dwait >= dmem_lat);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      iwait <= 0;
      dwait <= 0;
    end else begin
      iwait <= (imem_req && !imem_ack) ? iwait + 1 : 0;
      dwait <= (dmem_req && !dmem_ack) ? dwait + 1 : 0;
    end
  end

  wire [6:0]  strb     = {alu_op, alu_src_imm, acc_we, flags_we, out_we};
  wire [30:0] outs_vec = {imem_req, dmem_req, dmem_we, alu_src_imm, acc_we, flags_we, out_we,
                          halted, fault, alu_op, operand, dmem_addr, imem_addr, pc, state};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; step = 1'b0;
    zero_flag = 1'b0; carry_flag = 1'b0;
    imem_lat = 0; dmem_lat = 0;
    for (int a = 0; a < 16; a++) prog[a] = 8'h00;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  task automatic step_once();
    step = 1'b1;
    cyc();
    step = 1'b0;
  endtask

  // Single LD/ST through a step, observing the MEM phase for 25 cycles.
  task automatic mem_test(input string name, input logic [7:0] instr, input int unsigned lat,
                          input int exp_req, input int exp_acc, input logic [2:0] exp_state);
    int n_req = 0, n_acc = 0, n_bad = 0;
    logic [6:0] acc_strb = '0;
    do_reset();
    prog[0] = instr;
    dmem_lat = lat;
    step_once();
    cyc();
    for (int k = 0; k < 25; k++) begin
      cyc();
      if (dmem_req) begin
        n_req++;
        if (dmem_addr !== instr[3:0] || dmem_we !== (instr[7:4] == 4'h8)) n_bad++;
      end
      if (acc_we) begin
        n_acc++;
        acc_strb = strb;
        if (!dmem_ack) n_bad++;
      end
    end
    check({name, " req cycles"}, n_req, exp_req);
    check({name, " acc_we pulses"}, n_acc, exp_acc);
    check({name, " addr/we/ack-cycle errors"}, n_bad, 0);
    check({name, " final state"}, state, exp_state);
    if (exp_acc != 0) check({name, " load strobes"}, acc_strb, 7'b000_0110);
  endtask

  typedef struct {
    logic [7:0] instr;
    logic       zf;
    logic       cf;
    logic [6:0] exp_strb;
    logic [3:0] exp_pc;
  } vec_t;

  vec_t vecs [16];

  logic [2:0] ops   [$];
  logic [3:0] opnds [$];
  logic [3:0] obs_pc [$], exp_pc [$];
  logic [6:0] obs_strb [$], exp_strb [$];
  logic [4:0] obs_mem [$], exp_mem [$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n_out, first_halt, n_after, n, n_fetch;
    bit done, stop;
    logic [3:0] mpc, op, arg;
    logic [7:0] instr;

    vecs[0]  = '{8'h00, 1'b0, 1'b0, 7'b000_0000, 4'd1};
    vecs[1]  = '{8'h15, 1'b0, 1'b0, 7'b000_1110, 4'd1};
    vecs[2]  = '{8'h23, 1'b0, 1'b0, 7'b001_1110, 4'd1};
    vecs[3]  = '{8'h3A, 1'b0, 1'b0, 7'b010_1110, 4'd1};
    vecs[4]  = '{8'h4F, 1'b0, 1'b0, 7'b011_1110, 4'd1};
    vecs[5]  = '{8'h51, 1'b0, 1'b0, 7'b100_1110, 4'd1};
    vecs[6]  = '{8'h66, 1'b0, 1'b0, 7'b101_1110, 4'd1};
    vecs[7]  = '{8'hC0, 1'b0, 1'b0, 7'b000_0001, 4'd1};
    vecs[8]  = '{8'hD0, 1'b0, 1'b0, 7'b110_0110, 4'd1};
    vecs[9]  = '{8'hE0, 1'b0, 1'b0, 7'b111_0110, 4'd1};
    vecs[10] = '{8'h9C, 1'b0, 1'b0, 7'b000_0000, 4'd12};
    vecs[11] = '{8'hA7, 1'b1, 1'b0, 7'b000_0000, 4'd7};
    vecs[12] = '{8'hA7, 1'b0, 1'b1, 7'b000_0000, 4'd1};
    vecs[13] = '{8'hB2, 1'b0, 1'b1, 7'b000_0000, 4'd2};
    vecs[14] = '{8'hB2, 1'b1, 1'b0, 7'b000_0000, 4'd1};
    vecs[15] = '{8'hD9, 1'b1, 1'b1, 7'b110_0110, 4'd1};

    // Reset state, during reset and while idle with run=step=0.
    for (int a = 0; a < 16; a++) prog[a] = 8'h00;
    #12;
    check("outputs during reset", outs_vec, 0);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc();
      check($sformatf("idle outputs cycle %0d", k), outs_vec, 0);
    end

    // One instruction per vector, single-stepped from pc=0.
    for (int i = 0; i < 16; i++) begin
      do_reset();
      prog[0] = vecs[i].instr;
      zero_flag = vecs[i].zf;
      carry_flag = vecs[i].cf;
      step_once();
      cyc();
      cyc();
      check($sformatf("v%0d exec state", i), state, 3);
      check($sformatf("v%0d exec strobes", i), strb, vecs[i].exp_strb);
      check($sformatf("v%0d operand", i), operand, vecs[i].instr[3:0]);
      cyc();
      check($sformatf("v%0d pc after", i), pc, vecs[i].exp_pc);
      check($sformatf("v%0d back to idle", i), state, 0);
    end

    // Free-run program LDI 5, ADD 3, OUT, HLT with zero-wait fetches.
    do_reset();
    prog[0] = 8'h15; prog[1] = 8'h23; prog[2] = 8'hC0; prog[3] = 8'hFF;
    run = 1'b1;
    ops.delete(); opnds.delete();
    n_out = 0; first_halt = -1; n_after = 0;
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (acc_we) begin
        ops.push_back(alu_op);
        opnds.push_back(operand);
      end
      if (out_we) n_out++;
      if (halted && first_halt < 0) first_halt = c;
      if (halted && (strb != 0 || imem_req || dmem_req)) n_after++;
    end
    check("prog acc_we pulses", ops.size(), 2);
    if (ops.size() == 2) begin
      check("prog alu_op #1", ops[0], 0);
      check("prog alu_op #2", ops[1], 1);
      check("prog operand #1", opnds[0], 5);
      check("prog operand #2", opnds[1], 3);
    end
    check("prog out_we pulses", n_out, 1);
    check("prog halt cycle", first_halt, 12);
    check("prog final pc", pc, 4);
    check("prog activity after halt", n_after, 0);
    step_once();
    run = 1'b0;
    cyc();
    check("halt ignores run/step", {halted, fault, state}, {1'b1, 1'b0, 3'd5});

    // Data memory: delayed load, zero-wait store, store that never gets acked.
    mem_test("LD 73", 8'h73, 3, 4, 1, 3'd0);
    mem_test("ST 85", 8'h85, 0, 1, 0, 3'd0);
    mem_test("ST timeout", 8'h8A, 100, 15, 0, 3'd6);

    // Fetch timeout: no ack ever.
    do_reset();
    imem_lat = 100;
    step_once();
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (imem_req) n++;
      cyc();
    end
    check("timeout req cycles", n, 15);
    check("timeout fault state", {fault, imem_req, state}, {1'b1, 1'b0, 3'd6});
    run = 1'b1;
    step_once();
    repeat (3) cyc();
    check("fault is sticky", {fault, halted, state}, {1'b1, 1'b0, 3'd6});
    do_reset();
    check("rst clears fault", {fault, state}, {1'b0, 3'd0});

    // Ack arriving on the cycle the limit is reached wins.
    do_reset();
    imem_lat = 14;
    step_once();
    repeat (15) cyc();
    check("ack at limit: state", state, 2);
    check("ack at limit: fault", fault, 0);

    // PC wrap: JMP 15, then fetch at 15, and step runs exactly one instruction.
    do_reset();
    prog[0] = 8'h9F;
    step_once();
    repeat (3) cyc();
    check("jmp to 15", pc, 15);
    step_once();
    check("fetch address 15", imem_addr, 15);
    cyc();
    check("pc wraps to 0", pc, 0);
    repeat (5) cyc();
    check("one step then idle", {state, pc}, {3'd0, 4'd0});

    // Reset in the middle of a data request.
    do_reset();
    prog[0] = 8'h73;
    dmem_lat = 100;
    step_once();
    cyc();
    cyc();
    check("mid-mem req high", dmem_req, 1);
    #1 rst = 1'b1;
    #1;
    check("async rst drops req", {dmem_req, state, pc}, {1'b0, 3'd0, 4'd0});
    cyc();
    rst = 1'b0;

    // Random programs, random ack latencies, checked against an ISA-level model.
    for (int t = 0; t < 8; t++) begin
      do_reset();
      for (int a = 0; a < 16; a++) prog[a] = 8'($urandom_range(0, 255));
      zero_flag  = 1'($urandom_range(0, 1));
      carry_flag = 1'($urandom_range(0, 1));
      imem_lat   = $urandom_range(0, 3);
      dmem_lat   = $urandom_range(0, 3);
      obs_pc.delete(); obs_strb.delete(); obs_mem.delete();
      exp_pc.delete(); exp_strb.delete(); exp_mem.delete();
      n_fetch = 0;
      done = 1'b0;
      run = 1'b1;
      for (int c = 0; c < 600 && !done; c++) begin
        cyc();
        if (imem_req && imem_ack) begin
          obs_pc.push_back(imem_addr);
          n_fetch++;
          if (n_fetch == 24) run = 1'b0;
        end
        if (acc_we || flags_we || out_we) obs_strb.push_back(strb);
        if (dmem_req && dmem_ack) obs_mem.push_back({dmem_we, dmem_addr});
        if (!imem_req) imem_lat = $urandom_range(0, 3);
        if (!dmem_req) dmem_lat = $urandom_range(0, 3);
        step = run && ($urandom_range(0, 1) == 1);
        if ((!run && state == 3'd0) || halted || fault) done = 1'b1;
      end
      step = 1'b0;
      check($sformatf("rand%0d finished in budget", t), done, 1);

      mpc = 4'd0;
      stop = 1'b0;
      for (int k = 0; k < 24 && !stop; k++) begin
        instr = prog[mpc];
        exp_pc.push_back(mpc);
        mpc = mpc + 4'd1;
        op  = instr[7:4];
        arg = instr[3:0];
        case (op)
          4'h1: exp_strb.push_back(7'b000_1110);
          4'h2: exp_strb.push_back(7'b001_1110);
          4'h3: exp_strb.push_back(7'b010_1110);
          4'h4: exp_strb.push_back(7'b011_1110);
          4'h5: exp_strb.push_back(7'b100_1110);
          4'h6: exp_strb.push_back(7'b101_1110);
          4'h7: begin
            exp_strb.push_back(7'b000_0110);
            exp_mem.push_back({1'b0, arg});
          end
          4'h8: exp_mem.push_back({1'b1, arg});
          4'h9: mpc = arg;
          4'hA: if (zero_flag) mpc = arg;
          4'hB: if (carry_flag) mpc = arg;
          4'hC: exp_strb.push_back(7'b000_0001);
          4'hD: exp_strb.push_back(7'b110_0110);
          4'hE: exp_strb.push_back(7'b111_0110);
          4'hF: stop = 1'b1;
          default: ;
        endcase
      end

      check($sformatf("rand%0d fetch count", t), obs_pc.size(), exp_pc.size());
      check($sformatf("rand%0d strobe count", t), obs_strb.size(), exp_strb.size());
      check($sformatf("rand%0d mem count", t), obs_mem.size(), exp_mem.size());
      for (int k = 0; k < obs_pc.size() && k < exp_pc.size(); k++)
        check($sformatf("rand%0d fetch addr %0d", t, k), obs_pc[k], exp_pc[k]);
      for (int k = 0; k < obs_strb.size() && k < exp_strb.size(); k++)
        check($sformatf("rand%0d strobe %0d", t, k), obs_strb[k], exp_strb[k]);
      for (int k = 0; k < obs_mem.size() && k < exp_mem.size(); k++)
        check($sformatf("rand%0d mem %0d", t, k), obs_mem[k], exp_mem[k]);
      check($sformatf("rand%0d halted", t), halted, stop);
      check($sformatf("rand%0d no fault", t), fault, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
